// File: rtl/serial_subtractor_pkg.sv
// ---------------------------------------------------------------------------
// serial_subtractor_pkg
// Shared definitions for the bit-serial arithmetic blocks.
//   state_t       : FSM state encoding (IDLE / RUN / DONE), shared so other
//                   serial arithmetic units decode states identically.
//   countWidth()  : width of a bit counter that must reach the value 'width'.
// ---------------------------------------------------------------------------
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter must be able to represent 0..width, hence width+1 values.
    function automatic int countWidth(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// ---------------------------------------------------------------------------
// full_subtractor
// One-bit combinational subtractor cell computing a - b - bin.
// Ports:
//   a    : minuend bit
//   b    : subtrahend bit
//   bin  : borrow-in
//   dout : difference bit
//   bout : borrow-out
// ---------------------------------------------------------------------------
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic dout,
    output logic bout
);

    // A borrow is needed when b exceeds a, or when a equals b and a borrow
    // is already pending from the lower bit.
    assign dout = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
// Bit-serial subtractor computing a - b - bin over WIDTH clock cycles using a
// single full_subtractor cell, LSB first.
// Parameters:
//   WIDTH : operand width in bits (2..32)
// Ports:
//   clk   : clock, rising edge
//   rst   : asynchronous active-high reset
//   start : begin a subtraction (honoured only in IDLE)
//   a     : minuend
//   b     : subtrahend
//   bin   : borrow-in
//   busy  : high in RUN and DONE
//   done  : one-cycle pulse when a new result is presented
//   diff  : (a - b - bin) mod 2^WIDTH
//   bout  : unsigned borrow-out (a < b + bin)
//   ovf   : two's-complement signed overflow
// ---------------------------------------------------------------------------
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    import serial_subtractor_pkg::*;

    localparam int            CW   = countWidth(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic             r_borrow;
    logic [CW-1:0]    r_count;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_diff;
    logic             r_bout;
    logic             r_ovf;

    logic             w_dout;
    logic             w_bout;
    logic [WIDTH-1:0] w_resNext;

    // The single shared cell always works on bit 0 of the operand shift
    // registers; shifting them right each RUN cycle walks it up the word.
    full_subtractor u_cell (
        .a    (r_a[0]),
        .b    (r_b[0]),
        .bin  (r_borrow),
        .dout (w_dout),
        .bout (w_bout)
    );

    // Difference bits enter at the MSB so that after WIDTH shifts the first
    // (LSB) result bit has arrived at bit 0.
    assign w_resNext = {w_dout, r_res[WIDTH-1:1]};

    // Control FSM and datapath. On the final RUN cycle r_a[0]/r_b[0] hold the
    // captured operand sign bits, so overflow is decided from them and the
    // freshly computed MSB of the difference without extra storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_res    <= '0;
            r_borrow <= 1'b0;
            r_count  <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_diff   <= '0;
            r_bout   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a      <= a;
                        r_b      <= b;
                        r_borrow <= bin;
                        r_count  <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= RUN;
                    end
                end
                RUN: begin
                    r_a      <= r_a >> 1;
                    r_b      <= r_b >> 1;
                    r_res    <= w_resNext;
                    r_borrow <= w_bout;
                    r_count  <= r_count + CW'(1);
                    if (r_count == LAST) begin
                        r_diff  <= w_resNext;
                        r_bout  <= w_bout;
                        r_ovf   <= (r_a[0] != r_b[0]) && (w_dout != r_a[0]);
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign diff = r_diff;
    assign bout = r_bout;
    assign ovf  = r_ovf;

endmodule
